// File: rtl/mem_arbiter_rr_pkg.sv
// Shared types and default widths for the round-robin memory arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

  localparam int ARB_DEFAULT_NUM_PORTS = 2;
  localparam int ARB_DEFAULT_LINE_W    = 256;
  localparam int ARB_DEFAULT_ADDR_W    = 32;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin search: first set bit of mask at or after ptr, wrapping.
module rr_picker #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = 1
) (
  input  logic [NUM_PORTS-1:0] mask,
  input  logic [IDX_W-1:0]     ptr,
  output logic [IDX_W-1:0]     winner,
  output logic                 valid
);

  // Walk offsets from farthest to nearest so the nearest requester overwrites last.
  always_comb begin
    winner = '0;
    valid  = |mask;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      logic [IDX_W:0] sum;
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_PORTS))
        sum = sum - (IDX_W+1)'(NUM_PORTS);
      if (mask[sum[IDX_W-1:0]])
        winner = sum[IDX_W-1:0];
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port round-robin cacheline arbiter with a latched grant slot (IDLE/BUSY/DONE).
// Define MEM_ARB_WRITE_PRIO_EN to grant pending writes ahead of reads.
module mem_arbiter_rr
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = ARB_DEFAULT_NUM_PORTS,
  parameter int LINE_W    = ARB_DEFAULT_LINE_W,
  parameter int ADDR_W    = ARB_DEFAULT_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req_read,
  input  logic [NUM_PORTS-1:0]        req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_resp,
  output logic [LINE_W-1:0]           req_rdata,
  output logic                        cache_read,
  output logic                        cache_write,
  output logic [ADDR_W-1:0]           cache_addr,
  output logic [LINE_W-1:0]           cache_wdata,
  input  logic                        cache_resp,
  input  logic [LINE_W-1:0]           cache_rdata
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  arb_state_e         state_reg;
  arb_op_e            op_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   ptr_next;
  logic [IDX_W-1:0]   grant_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [LINE_W-1:0]  wdata_reg;

  logic [NUM_PORTS-1:0] req_any;
  logic [NUM_PORTS-1:0] pick_mask;
  logic [IDX_W-1:0]     winner;
  logic                 winner_valid;
  logic                 busy;
  logic                 done_now;

  assign req_any = req_read | req_write;

`ifdef MEM_ARB_WRITE_PRIO_EN
  // Any pending write narrows the search to writers so writebacks drain first.
  assign pick_mask = (|req_write) ? req_write : req_any;
`else
  assign pick_mask = req_any;
`endif

  rr_picker #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .mask   (pick_mask),
    .ptr    (ptr_reg),
    .winner (winner),
    .valid  (winner_valid)
  );

  generate
    if (NUM_PORTS == 1) begin : g_ptr_single
      assign ptr_next = '0;
    end else begin : g_ptr_multi
      assign ptr_next = (grant_reg == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_reg + IDX_W'(1);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      op_reg    <= OP_READ;
      ptr_reg   <= '0;
      grant_reg <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (winner_valid) begin
            grant_reg <= winner;
            op_reg    <= req_write[winner] ? OP_WRITE : OP_READ;
            addr_reg  <= req_addr[winner*ADDR_W +: ADDR_W];
            wdata_reg <= req_wdata[winner*LINE_W +: LINE_W];
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          if (cache_resp) begin
            ptr_reg   <= ptr_next;
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = (state_reg == BUSY);
  assign done_now = busy & cache_resp;

  assign cache_read  = busy & (op_reg == OP_READ);
  assign cache_write = busy & (op_reg == OP_WRITE);
  assign cache_addr  = busy ? addr_reg : '0;
  assign cache_wdata = busy ? wdata_reg : '0;
  assign req_rdata   = done_now ? cache_rdata : '0;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp
      assign req_resp[gi] = done_now & (grant_reg == IDX_W'(gi));
    end
  endgenerate

  // A port raising both read and write is a requester bug; it is served as a write.
  always_ff @(posedge clk) begin
    if (reset_n && state_reg == IDLE)
      assert (!(|(req_read & req_write)));
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr: a 2-port and a 4-port instance share clock,
// reset and the downstream response lines; the downstream side is driven by hand.
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         cache_resp;
  logic [255:0] cache_rdata;

  logic [1:0]   r2_read, r2_write, resp2;
  logic [63:0]  r2_addr;
  logic [511:0] r2_wdata;
  logic [255:0] rdata2, c2_wdata;
  logic         c2_read, c2_write;
  logic [31:0]  c2_addr;

  logic [3:0]    r4_read, r4_write, resp4;
  logic [127:0]  r4_addr;
  logic [1023:0] r4_wdata;
  logic [255:0]  rdata4, c4_wdata;
  logic          c4_read, c4_write;
  logic [31:0]   c4_addr;

  mem_arbiter_rr #(.NUM_PORTS(2), .LINE_W(256), .ADDR_W(32)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .req_read(r2_read), .req_write(r2_write), .req_addr(r2_addr), .req_wdata(r2_wdata),
    .req_resp(resp2), .req_rdata(rdata2),
    .cache_read(c2_read), .cache_write(c2_write), .cache_addr(c2_addr), .cache_wdata(c2_wdata),
    .cache_resp(cache_resp), .cache_rdata(cache_rdata)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .LINE_W(256), .ADDR_W(32)) u_dut4 (
    .clk(clk), .reset_n(reset_n),
    .req_read(r4_read), .req_write(r4_write), .req_addr(r4_addr), .req_wdata(r4_wdata),
    .req_resp(resp4), .req_rdata(rdata4),
    .cache_read(c4_read), .cache_write(c4_write), .cache_addr(c4_addr), .cache_wdata(c4_wdata),
    .cache_resp(cache_resp), .cache_rdata(cache_rdata)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Waits for the selected DUT to go busy, answers after lat cycles, samples at resp.
  task automatic serve(input int sel, input int lat, input logic [255:0] data,
                       output logic [3:0] resp, output logic [255:0] rdata,
                       output logic [31:0] addr, output logic wr, output logic [255:0] wdata,
                       output int busy_n, output int idle_n);
    logic act;
    act = 1'b0; idle_n = 0; busy_n = 0;
    resp = '0; rdata = '0; addr = '0; wr = 1'b0; wdata = '0;
    for (int i = 0; i < 20 && !act; i++) begin
      @(negedge clk);
      act = (sel != 0) ? (c4_read | c4_write) : (c2_read | c2_write);
      if (!act) idle_n++;
    end
    if (!act) begin
      total++;
      $error("FAIL serve_timeout observed=idle expected=busy");
      return;
    end
    busy_n = 1;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      if ((sel != 0) ? (c4_read | c4_write) : (c2_read | c2_write)) busy_n++;
    end
    cache_rdata = data;
    cache_resp  = 1'b1;
    #1;
    resp  = (sel != 0) ? resp4 : {2'b00, resp2};
    rdata = (sel != 0) ? rdata4 : rdata2;
    addr  = (sel != 0) ? c4_addr : c2_addr;
    wr    = (sel != 0) ? c4_write : c2_write;
    wdata = (sel != 0) ? c4_wdata : c2_wdata;
    @(posedge clk);
    #1;
    cache_resp  = 1'b0;
    cache_rdata = '0;
    $display("txn dut=%0d resp=%b addr=%h write=%0d busy=%0d idle=%0d", sel, resp, addr, wr, busy_n, idle_n);
  endtask

  logic [3:0]   s_resp;
  logic [255:0] s_rdata, s_wdata;
  logic [31:0]  s_addr;
  logic         s_wr;
  int           s_busy, s_idle;
  logic [255:0] pat_a5, pat_wd;
  logic [3:0]   exp4;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_wd = {8{32'hDEADBEEF}};
    reset_n = 1'b0; cache_resp = 1'b0; cache_rdata = '0;
    r2_read = '0; r2_write = '0; r2_addr = '0; r2_wdata = '0;
    r4_read = '0; r4_write = '0; r4_addr = '0; r4_wdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cache_read", c2_read, 0);
    chk("rst_cache_write", c2_write, 0);
    chk("rst_req_resp", resp2, 0);
    chk("rst_cache_addr", c2_addr, 0);
    chk("rst_req_rdata", rdata2, 0);
    reset_n = 1'b1;

    // Single read from port 1
    @(negedge clk);
    r2_read = 2'b10; r2_addr[63:32] = 32'h0000_1000;
    serve(0, 5, pat_a5, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
    chk("single_resp", s_resp, 4'b0010);
    chk("single_rdata", s_rdata, pat_a5);
    chk("single_addr", s_addr, 32'h0000_1000);
    chk("single_busy_cycles", s_busy, 5);
    chk("single_is_read", s_wr, 0);
    @(negedge clk);
    chk("done_cache_read", c2_read, 0);
    chk("done_req_resp", resp2, 0);

    // Both ports held: grants alternate with two idle cycles between
    r2_read = 2'b11; r2_addr = {32'h80, 32'h40};
    for (int k = 0; k < 4; k++) begin
      serve(0, 2, '0, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
      chk("alt_resp", s_resp, (k % 2 == 0) ? 4'b0001 : 4'b0010);
      chk("alt_addr", s_addr, (k % 2 == 0) ? 32'h40 : 32'h80);
      if (k > 0) chk("alt_gap", s_idle, 2);
    end
    r2_read = 2'b00;

    // Address stability while busy
    repeat (2) @(negedge clk);
    r2_read = 2'b01; r2_addr[31:0] = 32'h100;
    @(posedge clk);
    #1;
    r2_addr[31:0] = 32'h200;
    serve(0, 4, '0, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
    chk("stable_addr", s_addr, 32'h100);
    chk("stable_resp", s_resp, 4'b0001);
    r2_read = 2'b00;

    // Simultaneous read (port 0) and write (port 1) from ptr=0
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    r2_read = 2'b01; r2_addr = {32'h2000, 32'h3000};
    r2_write = 2'b10; r2_wdata[511:256] = pat_wd;
    serve(0, 3, pat_a5, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
`ifdef MEM_ARB_WRITE_PRIO_EN
    chk("prio_first_resp", s_resp, 4'b0010);
    chk("prio_first_write", s_wr, 1);
    chk("prio_first_addr", s_addr, 32'h2000);
    chk("prio_first_wdata", s_wdata, pat_wd);
    r2_write = 2'b00;
    serve(0, 3, pat_a5, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
    chk("prio_second_resp", s_resp, 4'b0001);
    chk("prio_second_write", s_wr, 0);
`else
    chk("rr_first_resp", s_resp, 4'b0001);
    chk("rr_first_write", s_wr, 0);
    chk("rr_first_addr", s_addr, 32'h3000);
    r2_read = 2'b00;
    serve(0, 3, pat_a5, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
    chk("rr_second_resp", s_resp, 4'b0010);
    chk("rr_second_write", s_wr, 1);
    chk("rr_second_wdata", s_wdata, pat_wd);
`endif
    r2_read = 2'b00; r2_write = 2'b00;

    // Advance ptr to 1, then reset mid-BUSY while port 1 is granted
    repeat (2) @(negedge clk);
    r2_read = 2'b01; r2_addr = {32'h500, 32'h400};
    serve(0, 2, '0, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
    chk("pre_reset_resp", s_resp, 4'b0001);
    r2_read = 2'b00;
    repeat (2) @(negedge clk);
    r2_read = 2'b11;
    @(posedge clk);
    #1;
    chk("pre_reset_addr", c2_addr, 32'h500);
    @(negedge clk);
    reset_n = 1'b0; cache_resp = 1'b1;
    #1;
    chk("midrst_cache_read", c2_read, 0);
    chk("midrst_req_resp", resp2, 0);
    @(negedge clk);
    reset_n = 1'b1; cache_resp = 1'b0;
    serve(0, 2, '0, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
    chk("post_reset_resp", s_resp, 4'b0001);
    chk("post_reset_addr", s_addr, 32'h400);
    r2_read = 2'b00;

    // Four ports all requesting: order 0,1,2,3,0 with two idle cycles between
    repeat (2) @(negedge clk);
    r4_read = 4'hF;
    r4_addr = {32'h30, 32'h20, 32'h10, 32'h00};
    for (int k = 0; k < 5; k++) begin
      serve(1, 2, '0, s_resp, s_rdata, s_addr, s_wr, s_wdata, s_busy, s_idle);
      exp4 = 4'b0001 << (k % 4);
      chk("rr4_resp", s_resp, exp4);
      chk("rr4_addr", s_addr, 32'((k % 4) * 16));
      if (k > 0) chk("rr4_gap", s_idle, 2);
    end
    r4_read = 4'h0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised round-robin memory arbiter for N cacheline-granularity requesters, e.g. L1 I-cache, L1 D-cache and prefetchers, sharing one downstream port. The downstream port is either the L2 cache or the cacheline adaptor. It generalises the fixed two-port I/D arbiter:
- configurable port count;
- fair round-robin grant;
- request latching so downstream signals stay stable for the whole transaction;
- optional write-priority mode.

## Interface
Parameters:
- NUM_PORTS, 2, number of requesters (>=1); port 0 = I-cache, port 1 = D-cache in the mp4 top.
- LINE_W, 256, cacheline width in bits.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- req_read  in  NUM_PORTS  per-port read request, held until that port's resp.
- req_write  in  NUM_PORTS  per-port write request, held until that port's resp.
- req_addr  in  NUM_PORTS*ADDR_W  per-port line address, packed, port i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*LINE_W  per-port write line, packed likewise.
- req_resp  out  NUM_PORTS  one-hot completion pulse to the granted port.
- req_rdata  out  LINE_W  read line, broadcast to all ports; valid only with req_resp.
- cache_read  out  1  downstream read.
- cache_write  out  1  downstream write.
- cache_addr  out  ADDR_W  downstream address.
- cache_wdata  out  LINE_W  downstream write line.
- cache_resp  in  1  downstream completion.
- cache_rdata  in  LINE_W  downstream read line.

## Operation
- Three states: IDLE, BUSY, DONE.
- IDLE:
  - Port i is requesting if req_read[i] | req_write[i].
  - If any port requests, pick a winner by round-robin: search ports ptr, ptr+1, … mod NUM_PORTS, taking the first requesting port.
  - Register into the grant slot: grant index g, op (write if req_write[g], else read), req_addr[g] and req_wdata[g].
  - Next state is BUSY.
- BUSY:
  - cache_read/cache_write are driven from the latched op; cache_addr/cache_wdata are driven from the latched slot.
  - On cache_resp: req_resp[g]=1 combinationally in the same cycle, req_rdata = cache_rdata pass-through. Next state is DONE; ptr <= (g+1) mod NUM_PORTS.
- DONE:
  - One dead cycle: no grant, all outputs idle, so a requester has time to drop its request.
  - Next state is IDLE.
- Port asserts both read and write: treated as write; simulation assertion fires.
- Requester drops its request while BUSY: the downstream transaction still completes; the resp pulse is still issued and ignored by the requester.
- cache_resp outside BUSY is ignored.
- NUM_PORTS=1: ptr is constant 0; behaviour is a registered pass-through.

## Timing
- Reset (async assert, synchronous-to-clk deassert):
  - state=IDLE, ptr=0;
  - req_resp=0, cache_read=0, cache_write=0;
  - cache_addr=0, cache_wdata=0, req_rdata=0.
- Request seen in IDLE at cycle t → cache_read/cache_write high at t+1.
- cache_resp at cycle r → req_resp[g] high in cycle r only. cache_read/cache_write drop at r+1 (DONE). The earliest next grant decision is at r+2 (IDLE).
- Minimum turnaround between back-to-back transactions: 2 cycles of downstream idle (DONE, IDLE).
- cache_addr/cache_wdata/op are constant from t+1 through r regardless of requester inputs.
- Reset asserted mid-transaction: outputs clear immediately, with no resp issued. Downstream is reset on the same reset_n.

## Configuration
- MEM_ARB_WRITE_PRIO_EN defined:
  - In IDLE, if any port has req_write asserted, the round-robin search runs over write requesters only.
  - Reads are granted only when no write is pending.
  - ptr update is unchanged.
  - Purpose: dirty writebacks drain before refills.
- Not defined: pure round-robin over all requesters, read and write alike.

## Structure
- Package arb_pkg holds:
  - the arb_state_e enum (IDLE, BUSY, DONE);
  - arb_op_e (OP_READ, OP_WRITE);
  - localparam-independent constants such as ARB_DEFAULT_LINE_W=256.
- Index width: IDX_W = (NUM_PORTS>1) ? $clog2(NUM_PORTS) : 1, local to the module.
- One sub-module, rr_picker: combinational first-requester search from ptr over a NUM_PORTS mask, giving winner index and valid. It is instantiated once. In write-priority mode a write-mask pre-select in front of it chooses which mask is presented.

## Test plan
- Single read: port 1 reads 0x0000_1000, downstream resp after 5 cycles with 0xA5…A5 → req_resp=2'b10 for 1 cycle, req_rdata=0xA5…A5, cache_read high exactly 5 cycles.
- Simultaneous requests after reset: ports 0 and 1 both read → port 0 served first, then port 1. With both held continuously the grants alternate 0,1,0,1.
- NUM_PORTS=4, all request continuously → grant order 0,1,2,3,0; each downstream transaction separated by exactly 2 idle cycles.
- Address stability: port 0 changes req_addr from 0x100 to 0x200 while BUSY → cache_addr stays 0x100 until resp.
- With MEM_ARB_WRITE_PRIO_EN and ptr=0: port 0 reads and port 1 writes 0x2000 simultaneously → port 1's write is granted first. Without the macro → port 0's read is granted first.
- Reset pulse (reset_n low 1 cycle) mid-BUSY → cache_read=0 immediately, no req_resp. A new request afterwards is served from ptr=0.
